// File: rtl/mem_seq_if.sv
// Request/strobe bundle between the NARC memory access sequencer and its
// neighbours (request source, register unit controls, memory strobes).
interface mem_seq_if;
    logic       req;
    logic       wr;
    logic [2:0] areg;
    logic [1:0] dreg;
    logic       mem_rdy;
    logic [2:0] rsel;
    logic       oe;
    logic [1:0] wsel;
    logic       wren;
    logic       mem_ce_n;
    logic       mem_oe_n;
    logic       mem_we_n;
    logic       ddrv_n;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req, wr, areg, dreg, mem_rdy,
        input  rsel, oe, wsel, wren, mem_ce_n, mem_oe_n, mem_we_n,
               ddrv_n, busy, done, err
    );

    modport slave (
        input  req, wr, areg, dreg, mem_rdy,
        output rsel, oe, wsel, wren, mem_ce_n, mem_oe_n, mem_we_n,
               ddrv_n, busy, done, err
    );
endinterface

// File: rtl/mem_seq.sv
// NARC memory access sequencer: one load or store per request through
// SETUP / STROBE / XFER / HOLD, with minimum wait states, ready and timeout.
module mem_seq #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 15
) (
    input logic      i_clk,
    input logic      i_rst,
    mem_seq_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_XFER,
        S_HOLD
    } state_t;

    localparam logic [4:0] LP_WS = 5'(WAIT_STATES);
    localparam logic [4:0] LP_TO = 5'(TIMEOUT);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_wr;
    logic [1:0] r_dreg;
    logic [2:0] r_rsel;
    logic       r_oe;
    logic [1:0] r_wsel;
    logic       r_wren;
    logic       r_mem_ce_n;
    logic       r_mem_oe_n;
    logic       r_mem_we_n;
    logic       r_ddrv_n;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic [4:0] w_cnt_inc;
    logic       w_ws_met;
    logic       w_to_hit;

    // Compare c+1 in 5 bits so TIMEOUT=15 cannot wrap the 4-bit counter.
    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
    assign w_ws_met  = (w_cnt_inc >= LP_WS);
    assign w_to_hit  = (w_cnt_inc == LP_TO);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rsel     <= 3'd0;
            r_oe       <= 1'b1;
            r_wsel     <= 2'd0;
            r_wren     <= 1'b1;
            r_mem_ce_n <= 1'b1;
            r_mem_oe_n <= 1'b1;
            r_mem_we_n <= 1'b1;
            r_ddrv_n   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.req) begin
                        r_wr       <= io_bus.wr;
                        r_dreg     <= io_bus.dreg;
                        r_rsel     <= io_bus.areg;
                        r_oe       <= 1'b0;
                        r_mem_ce_n <= 1'b0;
                        r_ddrv_n   <= ~io_bus.wr;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_cnt      <= 4'd0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt <= 4'd0;
                    if (r_wr) r_mem_we_n <= 1'b0;
                    else      r_mem_oe_n <= 1'b0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    // Ready wins over timeout when both land on the same cycle.
                    if (w_ws_met && io_bus.mem_rdy) begin
                        if (r_wr) begin
                            r_mem_we_n <= 1'b1;
                        end else begin
                            r_wsel <= r_dreg;
                            r_wren <= 1'b0;
                        end
                        r_state <= S_XFER;
                    end else if (w_to_hit) begin
                        r_rsel     <= 3'd0;
                        r_oe       <= 1'b1;
                        r_mem_ce_n <= 1'b1;
                        r_mem_oe_n <= 1'b1;
                        r_mem_we_n <= 1'b1;
                        r_ddrv_n   <= 1'b1;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_state    <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_XFER: begin
                    r_rsel     <= 3'd0;
                    r_oe       <= 1'b1;
                    r_wsel     <= 2'd0;
                    r_wren     <= 1'b1;
                    r_mem_ce_n <= 1'b1;
                    r_mem_oe_n <= 1'b1;
                    r_mem_we_n <= 1'b1;
                    r_ddrv_n   <= 1'b1;
                    r_done     <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.rsel     = r_rsel;
    assign io_bus.oe       = r_oe;
    assign io_bus.wsel     = r_wsel;
    assign io_bus.wren     = r_wren;
    assign io_bus.mem_ce_n = r_mem_ce_n;
    assign io_bus.mem_oe_n = r_mem_oe_n;
    assign io_bus.mem_we_n = r_mem_we_n;
    assign io_bus.ddrv_n   = r_ddrv_n;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.err      = r_err;
endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: default-timing instance and a 3-wait-state instance,
// a small register-unit model, and an access scoreboard checked on DONE.
module tb_mem_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, rdy, sel;
    logic [2:0]  areg;
    logic [1:0]  dreg;
    logic [15:0] data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_seq_if if_a ();
    mem_seq_if if_b ();

    assign if_a.req = req & ~sel;
    assign if_a.wr = wr;
    assign if_a.areg = areg;
    assign if_a.dreg = dreg;
    assign if_a.mem_rdy = rdy;
    assign if_b.req = req & sel;
    assign if_b.wr = wr;
    assign if_b.areg = areg;
    assign if_b.dreg = dreg;
    assign if_b.mem_rdy = rdy;

    mem_seq #(.WAIT_STATES(1), .TIMEOUT(15)) u_a (.i_clk(clk), .i_rst(rst), .io_bus(if_a));
    mem_seq #(.WAIT_STATES(3), .TIMEOUT(15)) u_b (.i_clk(clk), .i_rst(rst), .io_bus(if_b));

    // Output vector: rsel, oe, wsel, wren, ce_n, oe_n, we_n, ddrv_n, busy, done, err
    logic [13:0] vec_a, vec_b, m_vec;
    localparam logic [13:0] RST_VEC = 14'b000_1_00_1_1_1_1_1_0_0_0;
    assign vec_a = {if_a.rsel, if_a.oe, if_a.wsel, if_a.wren, if_a.mem_ce_n, if_a.mem_oe_n,
                    if_a.mem_we_n, if_a.ddrv_n, if_a.busy, if_a.done, if_a.err};
    assign vec_b = {if_b.rsel, if_b.oe, if_b.wsel, if_b.wren, if_b.mem_ce_n, if_b.mem_oe_n,
                    if_b.mem_we_n, if_b.ddrv_n, if_b.busy, if_b.done, if_b.err};
    assign m_vec = sel ? vec_b : vec_a;

    logic [2:0] m_rsel;
    logic [1:0] m_wsel;
    logic m_oe, m_wren, m_moe, m_mwe, m_ddrv, m_busy, m_done, m_err;
    assign m_rsel = m_vec[13:11];
    assign m_oe   = m_vec[10];
    assign m_wsel = m_vec[9:8];
    assign m_wren = m_vec[7];
    assign m_moe  = m_vec[5];
    assign m_mwe  = m_vec[4];
    assign m_ddrv = m_vec[3];
    assign m_busy = m_vec[2];
    assign m_done = m_vec[1];
    assign m_err  = m_vec[0];

    // Register unit: register 0 discards writes.
    logic [15:0] regs [4];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 16'h0000;
        end else if (!m_wren && m_wsel != 2'd0) begin
            regs[m_wsel] <= data;
        end
    end

    typedef struct {
        bit        wr;
        bit [2:0]  areg;
        bit [1:0]  dreg;
        bit [15:0] data;
        int        strobes;
        bit        tmo;
    } exp_t;
    exp_t sb[$];

    int a_oe, a_moe, a_mwe, a_ddrv, a_wren, a_busy, a_inv;
    logic [2:0] a_rsel;
    logic [1:0] a_wsel;
    bit a_rsel_bad, a_wsel_bad;

    always @(negedge clk) begin
        exp_t e;
        int oe_x, moe_x, mwe_x, ddrv_x, wren_x, busy_x;
        if (rst) begin
            a_oe = 0; a_moe = 0; a_mwe = 0; a_ddrv = 0; a_wren = 0; a_busy = 0; a_inv = 0;
            a_rsel_bad = 0; a_wsel_bad = 0; a_rsel = 3'd0; a_wsel = 2'd0;
        end else begin
            if ((!m_wren && m_moe) || (!m_wren && !m_mwe)) a_inv++;
            if (m_busy) begin
                if (!m_oe) begin
                    if (a_oe == 0) a_rsel = m_rsel;
                    else if (m_rsel !== a_rsel) a_rsel_bad = 1;
                    a_oe++;
                end
                if (!m_moe) a_moe++;
                if (!m_mwe) a_mwe++;
                if (!m_ddrv) a_ddrv++;
                if (!m_wren) begin a_wren++; a_wsel = m_wsel; end
                else if (m_wsel != 2'd0) a_wsel_bad = 1;
                a_busy++;
            end
            if (m_done) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty: DONE with no expected access");
                end else begin
                    e = sb.pop_front();
                    oe_x   = e.tmo ? e.strobes + 1 : e.strobes + 2;
                    moe_x  = e.wr ? 0 : (e.tmo ? e.strobes : e.strobes + 1);
                    mwe_x  = e.wr ? e.strobes : 0;
                    ddrv_x = e.wr ? oe_x : 0;
                    wren_x = (e.wr || e.tmo) ? 0 : 1;
                    busy_x = e.tmo ? e.strobes + 2 : e.strobes + 3;
                    checks++; if (a_oe !== oe_x) begin failures++; $display("FAIL sb_oe_cycles: got %0d want %0d", a_oe, oe_x); end
                    checks++; if ({a_rsel_bad, a_rsel} !== {1'b0, e.areg}) begin failures++; $display("FAIL sb_rsel: got bad=%0d rsel=%0d want %0d", a_rsel_bad, a_rsel, e.areg); end
                    checks++; if (a_moe !== moe_x) begin failures++; $display("FAIL sb_mem_oe_cycles: got %0d want %0d", a_moe, moe_x); end
                    checks++; if (a_mwe !== mwe_x) begin failures++; $display("FAIL sb_mem_we_cycles: got %0d want %0d", a_mwe, mwe_x); end
                    checks++; if (a_ddrv !== ddrv_x) begin failures++; $display("FAIL sb_ddrv_cycles: got %0d want %0d", a_ddrv, ddrv_x); end
                    checks++; if (a_wren !== wren_x) begin failures++; $display("FAIL sb_wren_cycles: got %0d want %0d", a_wren, wren_x); end
                    checks++; if (a_busy !== busy_x) begin failures++; $display("FAIL sb_busy_cycles: got %0d want %0d", a_busy, busy_x); end
                    checks++; if (m_err !== e.tmo) begin failures++; $display("FAIL sb_err: got %0b want %0b", m_err, e.tmo); end
                    checks++; if ({a_inv, a_wsel_bad} !== {32'd0, 1'b0}) begin failures++; $display("FAIL sb_strobe_rules: got inv=%0d wsel_stray=%0b want 0/0", a_inv, a_wsel_bad); end
                    if (wren_x == 1) begin
                        checks++; if (a_wsel !== e.dreg) begin failures++; $display("FAIL sb_wsel: got %0d want %0d", a_wsel, e.dreg); end
                        if (e.dreg != 2'd0) begin
                            checks++; if (regs[e.dreg] !== e.data) begin failures++; $display("FAIL sb_reg_write: got %h want %h", regs[e.dreg], e.data); end
                        end
                    end
                end
                a_oe = 0; a_moe = 0; a_mwe = 0; a_ddrv = 0; a_wren = 0; a_busy = 0; a_inv = 0;
                a_rsel_bad = 0; a_wsel_bad = 0;
            end
        end
    end

    task automatic do_req(input bit w, input logic [2:0] a, input logic [1:0] d);
        @(negedge clk);
        req = 1'b1; wr = w; areg = a; dreg = d;
        @(negedge clk);
        // Scramble the request fields; the sequencer must use its latched copy.
        req = 1'b0; wr = ~w; areg = ~a; dreg = ~d;
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        n = 0; ok = 0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (m_done) ok = 1;
        end
        if (!ok) $display("FAIL done_timeout: no DONE within %0d cycles", budget);
    endtask

    task automatic test_reset();
        bit wren_seen;
        rst = 1'b1; req = 1'b0; wr = 1'b0; rdy = 1'b1; sel = 1'b0;
        areg = 3'd0; dreg = 2'd0; data = 16'h0000;
        repeat (2) @(negedge clk);
        checks++; if ({vec_a, vec_b} !== {RST_VEC, RST_VEC}) begin failures++; $display("FAIL reset_values: got %b/%b want %b", vec_a, vec_b, RST_VEC); end
        rst = 1'b0;
        rdy = 1'b0;
        do_req(1'b0, 3'd2, 2'd1);
        repeat (2) @(negedge clk);
        checks++; if ({m_moe, m_busy} !== 2'b01) begin failures++; $display("FAIL reset_in_strobe: got oe_n/busy=%b want 01", {m_moe, m_busy}); end
        rst = 1'b1;
        wren_seen = 0;
        repeat (2) begin @(negedge clk); if (!m_wren) wren_seen = 1; end
        checks++; if (m_vec !== RST_VEC) begin failures++; $display("FAIL reset_mid_strobe: got %b want %b", m_vec, RST_VEC); end
        rst = 1'b0; rdy = 1'b1;
        repeat (3) begin @(negedge clk); if (!m_wren || m_busy) wren_seen = 1; end
        checks++; if (wren_seen !== 1'b0) begin failures++; $display("FAIL reset_no_wren: got activity=%0b want 0", wren_seen); end
        checks++; if (regs[1] !== 16'h0000) begin failures++; $display("FAIL reset_reg1: got %h want 0000", regs[1]); end
    endtask

    task automatic test_load_default();
        int n; bit ok;
        sel = 1'b0; rdy = 1'b1; data = 16'hBEEF;
        sb.push_back('{wr: 0, areg: 3'd1, dreg: 2'd2, data: 16'hBEEF, strobes: 1, tmo: 0});
        do_req(1'b0, 3'd1, 2'd2);
        wait_done(20, n, ok);
        if (!ok) failures++;
        // n counts from the edge after the request drive, so add one.
        checks++; if (n + 1 !== 4) begin failures++; $display("FAIL load_latency: got %0d want 4", n + 1); end
        checks++; if (regs[2] !== 16'hBEEF) begin failures++; $display("FAIL load_r2: got %h want BEEF", regs[2]); end
        @(negedge clk);
        checks++; if ({m_busy, m_done} !== 2'b00) begin failures++; $display("FAIL load_after_done: got busy/done=%b want 00", {m_busy, m_done}); end
    endtask

    task automatic test_store_ws3();
        int n; bit ok;
        sel = 1'b1; rdy = 1'b1; data = 16'h5555;
        sb.push_back('{wr: 1, areg: 3'd6, dreg: 2'd0, data: 16'h0000, strobes: 3, tmo: 0});
        do_req(1'b1, 3'd6, 2'd1);
        wait_done(30, n, ok);
        if (!ok) failures++;
        checks++; if (n + 1 !== 6) begin failures++; $display("FAIL store_latency: got %0d want 6", n + 1); end
        @(negedge clk);
        checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL store_busy_fall: got %0b want 0", m_busy); end
        sel = 1'b0;
    endtask

    task automatic test_ready_stretch();
        int n; bit ok;
        sel = 1'b0; rdy = 1'b0; data = 16'h1234;
        sb.push_back('{wr: 0, areg: 3'd3, dreg: 2'd1, data: 16'h1234, strobes: 5, tmo: 0});
        do_req(1'b0, 3'd3, 2'd1);
        repeat (5) @(negedge clk);
        rdy = 1'b1;
        wait_done(20, n, ok);
        if (!ok) failures++;
        checks++; if (6 + n !== 8) begin failures++; $display("FAIL stretch_latency: got %0d want 8", 6 + n); end
        checks++; if ({m_err, regs[1]} !== {1'b0, 16'h1234}) begin failures++; $display("FAIL stretch_result: got err=%0b r1=%h want 0/1234", m_err, regs[1]); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n; bit ok;
        sel = 1'b0; rdy = 1'b0; data = 16'hDEAD;
        sb.push_back('{wr: 0, areg: 3'd4, dreg: 2'd3, data: 16'hDEAD, strobes: 15, tmo: 1});
        do_req(1'b0, 3'd4, 2'd3);
        wait_done(40, n, ok);
        if (!ok) failures++;
        checks++; if (n + 1 !== 17) begin failures++; $display("FAIL timeout_latency: got %0d want 17", n + 1); end
        checks++; if ({m_err, regs[3]} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL timeout_result: got err=%0b r3=%h want 1/0000", m_err, regs[3]); end
        repeat (3) @(negedge clk);
        checks++; if ({m_err, m_busy} !== 2'b10) begin failures++; $display("FAIL timeout_err_sticky: got err/busy=%b want 10", {m_err, m_busy}); end
        rdy = 1'b1; data = 16'h7777;
        sb.push_back('{wr: 0, areg: 3'd0, dreg: 2'd0, data: 16'h7777, strobes: 1, tmo: 0});
        do_req(1'b0, 3'd0, 2'd0);
        checks++; if ({m_err, m_busy} !== 2'b01) begin failures++; $display("FAIL err_clear_on_accept: got err/busy=%b want 01", {m_err, m_busy}); end
        wait_done(20, n, ok);
        if (!ok) failures++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k; int dn; int d_at[3];
        sel = 1'b0; rdy = 1'b1; data = 16'hA5A5;
        sb.push_back('{wr: 0, areg: 3'd3, dreg: 2'd3, data: 16'hA5A5, strobes: 1, tmo: 0});
        sb.push_back('{wr: 0, areg: 3'd5, dreg: 2'd3, data: 16'hA5A5, strobes: 1, tmo: 0});
        sb.push_back('{wr: 0, areg: 3'd7, dreg: 2'd3, data: 16'hA5A5, strobes: 1, tmo: 0});
        @(negedge clk);
        req = 1'b1; wr = 1'b0; areg = 3'd3; dreg = 2'd3;
        k = 0; dn = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (m_done) begin
                if (dn < 3) d_at[dn] = k;
                dn++;
            end
            if (k == 2) areg = 3'd5;
            if (k == 7) areg = 3'd7;
            if (k == 11) req = 1'b0;
        end
        checks++; if (dn !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", dn); end
        if (dn >= 3) begin
            checks++; if (d_at[1] - d_at[0] !== 5) begin failures++; $display("FAIL b2b_period1: got %0d want 5", d_at[1] - d_at[0]); end
            checks++; if (d_at[2] - d_at[1] !== 5) begin failures++; $display("FAIL b2b_period2: got %0d want 5", d_at[2] - d_at[1]); end
        end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_default();
        test_store_ws3();
        test_ready_stretch();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
